mem_stage_pipe: RTL and testbench

- Parametrised successor of the five-stage MEM stage.
- Holds the data memory and the MEM/WB pipeline register. Adds a configurable number of memory wait-states, a valid/ready handshake with EX (stall), a flush input and an address-range error flag.
- Sits between the execute stage and register write-back. With LAT=0 it behaves cycle-for-cycle like the existing single-cycle MEM stage.

---
 rtl/mem_pkg.sv | 50 +++++
 rtl/dmem_wait.sv | 32 +++
 rtl/mem_stage_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage.
//   state_e     : MEM-stage FSM states (IDLE, WAIT)
//   SZ_*        : access-size encodings used when MEM_BYTE_EN is defined
//   CTRL_*      : default control-bundle width and bit positions
//   lane_mask   : byte-lane enables for a size/offset pair (32-bit word)
//   misaligned  : true when a half/word access does not sit on its natural boundary
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned CTRL_W_DEFAULT  = 14;
  localparam int unsigned CTRL_IS_RET     = 0;
  localparam int unsigned CTRL_IS_WB      = 1;
  localparam int unsigned CTRL_IS_IMM     = 2;
  localparam int unsigned CTRL_IS_BEQ     = 3;
  localparam int unsigned CTRL_IS_BGT     = 4;
  localparam int unsigned CTRL_IS_UBRANCH = 5;
  localparam int unsigned CTRL_IS_CALL    = 6;
  localparam int unsigned CTRL_ALU_LSB    = 7;
  localparam int unsigned CTRL_ALU_MSB    = 13;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_wait.sv
// Data memory array for the MEM stage.
//   clk   : rising-edge clock (writes only; contents are never reset)
//   we    : write enable, commits at the rising edge
//   be    : per-byte lane enables for the write
//   idx   : word index for both read and write
//   wdata : write data (lanes already positioned)
//   rdata : asynchronous read of the word at idx (old value during a write cycle)
module dmem_wait #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < XLEN/8; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: data memory with LAT wait-states, valid/ready stall
// towards EX, flush, address-range error, and the MEM/WB register.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : handshake with EX (in_ready=0 stalls EX/ID/IF)
//   flush_i           : drops the input and aborts an in-flight access
//   pc_i..regs_i      : instruction fields from EX
//   out_valid..regs_o : MEM/WB register contents
//   ld_result_o       : load data, addr_err_o : access was out of range
// Optional: define MEM_BYTE_EN to add size_i/sext_i byte/half accesses.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic [XLEN-1:0]     st_data_i,
  input  logic [XLEN-1:0]     instr_i,
  input  logic                is_ld_i,
  input  logic                is_st_i,
`ifdef MEM_BYTE_EN
  input  logic [1:0]          size_i,
  input  logic                sext_i,
`endif
  input  logic [CTRL_W-1:0]   ctrl_i,
  input  logic [4*REG_AW-1:0] regs_i,
  output logic                out_valid,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     alu_result_o,
  output logic [XLEN-1:0]     instr_o,
  output logic [XLEN-1:0]     ld_result_o,
  output logic                is_ld_o,
  output logic                is_st_o,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [4*REG_AW-1:0] regs_o,
  output logic                addr_err_o
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned BE_W    = XLEN / 8;
  localparam logic [3:0]  LAT_CNT = 4'(LAT);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     alu;
    logic [XLEN-1:0]     st_data;
    logic [XLEN-1:0]     instr;
    logic                ld;
    logic                st;
`ifdef MEM_BYTE_EN
    logic [1:0]          size;
    logic                sext;
`endif
    logic [CTRL_W-1:0]   ctrl;
    logic [4*REG_AW-1:0] regs;
  } req_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     alu;
    logic [XLEN-1:0]     instr;
    logic [XLEN-1:0]     ld_result;
    logic                ld;
    logic                st;
    logic [CTRL_W-1:0]   ctrl;
    logic [4*REG_AW-1:0] regs;
    logic                err;
  } wb_t;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  wb_t        wb_q, wb_d;

  req_t            in_req;
  req_t            rq;
  logic            accept;
  logic            capture;
  logic            req_err;
  logic            mem_we;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    in_req         = '0;
    in_req.pc      = pc_i;
    in_req.alu     = alu_result_i;
    in_req.st_data = st_data_i;
    in_req.instr   = instr_i;
    in_req.ld      = is_ld_i;
    in_req.st      = is_st_i;
`ifdef MEM_BYTE_EN
    in_req.size    = size_i;
    in_req.sext    = sext_i;
`endif
    in_req.ctrl    = ctrl_i;
    in_req.regs    = regs_i;
  end

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush_i;

  // In WAIT the memory and MEM/WB register work from the latched request;
  // in IDLE they work straight from the EX inputs (single-cycle path).
  assign rq = (state_q == WAIT) ? req_q : in_req;

  // Access decode: range check, byte lanes, load extraction.
  always_comb begin
    logic oor;
`ifdef MEM_BYTE_EN
    logic [1:0]      off;
    logic [XLEN-1:0] shifted;
`endif
    oor = |rq.alu[XLEN-1:IDX_W+2];
`ifdef MEM_BYTE_EN
    off     = rq.alu[1:0];
    req_err = oor || misaligned(rq.size, off);
    mem_be  = BE_W'(lane_mask(rq.size, off));
    case (rq.size)
      SZ_B:    mem_wdata = {BE_W{rq.st_data[7:0]}};
      SZ_H:    mem_wdata = {(XLEN/16){rq.st_data[15:0]}};
      default: mem_wdata = rq.st_data;
    endcase
    shifted = mem_rdata >> {off, 3'b000};
    case (rq.size)
      SZ_B:    ld_data = {{(XLEN-8){rq.sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = {{(XLEN-16){rq.sext & shifted[15]}}, shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
`else
    req_err   = oor;
    mem_be    = '1;
    mem_wdata = rq.st_data;
    ld_data   = mem_rdata;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    wb_d     = wb_q;
    wb_d.valid = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((is_ld_i || is_st_i) && (LAT != 0)) begin
            req_d   = in_req;
            cnt_d   = LAT_CNT;
            state_d = WAIT;
          end else begin
            capture = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      wb_d.valid     = 1'b1;
      wb_d.pc        = rq.pc;
      wb_d.alu       = rq.alu;
      wb_d.instr     = rq.instr;
      wb_d.ld_result = (rq.ld && !req_err) ? ld_data : '0;
      wb_d.ld        = rq.ld;
      wb_d.st        = rq.st;
      wb_d.ctrl      = rq.ctrl;
      wb_d.regs      = rq.regs;
      wb_d.err       = (rq.ld || rq.st) && req_err;
    end
  end

  assign mem_we = capture && rq.st && !req_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wb_q    <= wb_d;
    end
  end

  dmem_wait #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (rq.alu[IDX_W+1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign out_valid    = wb_q.valid;
  assign pc_o         = wb_q.pc;
  assign alu_result_o = wb_q.alu;
  assign instr_o      = wb_q.instr;
  assign ld_result_o  = wb_q.ld_result;
  assign is_ld_o      = wb_q.ld;
  assign is_st_o      = wb_q.st;
  assign ctrl_o       = wb_q.ctrl;
  assign regs_o       = wb_q.regs;
  assign addr_err_o   = wb_q.err;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: one instance with LAT=0, one with LAT=2,
// both fed from the same EX-side signals.
module tb_mem_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_i = '0, alu_result_i = '0, st_data_i = '0, instr_i = '0;
  logic        is_ld_i = 1'b0, is_st_i = 1'b0;
  logic [13:0] ctrl_i = '0;
  logic [15:0] regs_i = '0;
`ifdef MEM_BYTE_EN
  logic [1:0]  size_i = 2'b10;
  logic        sext_i = 1'b0;
`endif

  logic        a0_in_ready, a0_out_valid, a0_is_ld, a0_is_st, a0_err;
  logic [31:0] a0_pc, a0_alu, a0_instr, a0_ld;
  logic [13:0] a0_ctrl;
  logic [15:0] a0_regs;
  logic        a2_in_ready, a2_out_valid, a2_is_ld, a2_is_st, a2_err;
  logic [31:0] a2_pc, a2_alu, a2_instr, a2_ld;
  logic [13:0] a2_ctrl;
  logic [15:0] a2_regs;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_stage_pipe #(.XLEN(32), .REG_AW(4), .CTRL_W(14), .DEPTH(1024), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a0_in_ready), .flush_i(flush_i),
    .pc_i(pc_i), .alu_result_i(alu_result_i), .st_data_i(st_data_i), .instr_i(instr_i),
    .is_ld_i(is_ld_i), .is_st_i(is_st_i),
`ifdef MEM_BYTE_EN
    .size_i(size_i), .sext_i(sext_i),
`endif
    .ctrl_i(ctrl_i), .regs_i(regs_i),
    .out_valid(a0_out_valid), .pc_o(a0_pc), .alu_result_o(a0_alu), .instr_o(a0_instr),
    .ld_result_o(a0_ld), .is_ld_o(a0_is_ld), .is_st_o(a0_is_st), .ctrl_o(a0_ctrl),
    .regs_o(a0_regs), .addr_err_o(a0_err)
  );

  mem_stage_pipe #(.XLEN(32), .REG_AW(4), .CTRL_W(14), .DEPTH(1024), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a2_in_ready), .flush_i(flush_i),
    .pc_i(pc_i), .alu_result_i(alu_result_i), .st_data_i(st_data_i), .instr_i(instr_i),
    .is_ld_i(is_ld_i), .is_st_i(is_st_i),
`ifdef MEM_BYTE_EN
    .size_i(size_i), .sext_i(sext_i),
`endif
    .ctrl_i(ctrl_i), .regs_i(regs_i),
    .out_valid(a2_out_valid), .pc_o(a2_pc), .alu_result_o(a2_alu), .instr_o(a2_instr),
    .ld_result_o(a2_ld), .is_ld_o(a2_is_ld), .is_st_o(a2_is_st), .ctrl_o(a2_ctrl),
    .regs_o(a2_regs), .addr_err_o(a2_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                       input logic ld, input logic st);
    in_valid     = 1'b1;
    pc_i         = pc;
    alu_result_i = alu;
    st_data_i    = sd;
    instr_i      = pc ^ 32'h0000_0013;
    is_ld_i      = ld;
    is_st_i      = st;
    ctrl_i       = pc[13:0];
    regs_i       = pc[15:0] ^ 16'hA5A5;
  endtask

  // Presents one access to the LAT=2 instance, then waits (bounded) for out_valid.
  task automatic mem_access(input logic ld, input logic st, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] pc,
                            output int cyc, output int stall, output bit timeout);
    drive(pc, addr, sd, ld, st);
    step();
    in_valid = 1'b0;
    cyc = 1;
    stall = 0;
    timeout = 1'b0;
    while (!a2_out_valid) begin
      if (!a2_in_ready) stall++;
      if (cyc >= 10) begin
        timeout = 1'b1;
        break;
      end
      step();
      cyc++;
    end
  endtask

  // Accepts an access on the LAT=2 instance and flushes it in its second WAIT cycle.
  task automatic flushed_access(input logic ld, input logic st, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] pc);
    drive(pc, addr, sd, ld, st);
    step();
    in_valid = 1'b0;
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    nvec++; if (a2_out_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %0b want 0", a2_out_valid); end
    nvec++; if (a2_pc !== 32'h0 || a2_alu !== 32'h0 || a2_instr !== 32'h0) begin nfail++; $display("FAIL rst_fields: pc %h alu %h instr %h want 0", a2_pc, a2_alu, a2_instr); end
    nvec++; if (a2_ld !== 32'h0 || a2_err !== 1'b0 || a2_ctrl !== 14'h0 || a2_regs !== 16'h0) begin nfail++; $display("FAIL rst_misc: ld %h err %b ctrl %h regs %h want 0", a2_ld, a2_err, a2_ctrl, a2_regs); end
    step();
    step();
    rst = 1'b1;
    step();
    nvec++; if (a2_in_ready !== 1'b1 || a0_in_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b/%b want 1/1", a0_in_ready, a2_in_ready); end
  endtask

  task automatic test_lat0_stream();
    logic [31:0] pcs [3];
    logic [31:0] res [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    res[0] = 32'h1111_1111; res[1] = 32'h0000_0007; res[2] = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(pcs[i], res[i], 32'h0, 1'b0, 1'b0);
      step();
      nvec++; if (a0_out_valid !== 1'b1 || a0_in_ready !== 1'b1) begin nfail++; $display("FAIL alu%0d_hs: valid %b ready %b want 1 1", i, a0_out_valid, a0_in_ready); end
      nvec++; if (a0_pc !== pcs[i] || a0_alu !== res[i]) begin nfail++; $display("FAIL alu%0d_data: pc %h alu %h want %h %h", i, a0_pc, a0_alu, pcs[i], res[i]); end
      nvec++; if (a0_instr !== (pcs[i] ^ 32'h13) || a0_ctrl !== pcs[i][13:0] || a0_regs !== (pcs[i][15:0] ^ 16'hA5A5) || a0_err !== 1'b0) begin
        nfail++; $display("FAIL alu%0d_pass: instr %h ctrl %h regs %h err %b", i, a0_instr, a0_ctrl, a0_regs, a0_err);
      end
    end
    in_valid = 1'b0;
    step();
    nvec++; if (a0_out_valid !== 1'b0 || a0_pc !== 32'h108) begin nfail++; $display("FAIL alu_idle: valid %b pc %h want 0 00000108", a0_out_valid, a0_pc); end
  endtask

  task automatic test_store_load();
    int cyc, stall; bit to;
    mem_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h200, cyc, stall, to);
    nvec++; if (to || cyc != 3) begin nfail++; $display("FAIL st_latency: got %0d cycles (timeout %0b) want 3", cyc, to); end
    nvec++; if (stall != 2) begin nfail++; $display("FAIL st_stall: got %0d want 2", stall); end
    nvec++; if (a2_pc !== 32'h200 || a2_is_st !== 1'b1 || a2_err !== 1'b0 || a2_in_ready !== 1'b1) begin nfail++; $display("FAIL st_out: pc %h st %b err %b ready %b", a2_pc, a2_is_st, a2_err, a2_in_ready); end
    mem_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h204, cyc, stall, to);
    nvec++; if (to || cyc != 3 || stall != 2) begin nfail++; $display("FAIL ld_latency: got %0d cycles %0d stalls want 3 2", cyc, stall); end
    nvec++; if (a2_ld !== 32'hDEAD_BEEF || a2_is_ld !== 1'b1) begin nfail++; $display("FAIL ld_data: got %h want deadbeef", a2_ld); end
    step();
    nvec++; if (a2_out_valid !== 1'b0) begin nfail++; $display("FAIL ld_oneshot: got %b want 0", a2_out_valid); end
  endtask

  task automatic test_flush();
    int cyc, stall; bit to;
    flushed_access(1'b0, 1'b1, 32'h10, 32'h1111_2222, 32'h300);
    nvec++; if (a2_out_valid !== 1'b0 || a2_in_ready !== 1'b1) begin nfail++; $display("FAIL fst_abort: valid %b ready %b want 0 1", a2_out_valid, a2_in_ready); end
    mem_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h304, cyc, stall, to);
    nvec++; if (to || a2_ld !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL fst_nowrite: got %h want deadbeef", a2_ld); end
    flushed_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h308);
    nvec++; if (a2_out_valid !== 1'b0 || a2_in_ready !== 1'b1 || a2_pc !== 32'h304) begin nfail++; $display("FAIL fld_abort: valid %b ready %b pc %h", a2_out_valid, a2_in_ready, a2_pc); end
    step();
    nvec++; if (a2_out_valid !== 1'b0) begin nfail++; $display("FAIL fld_late: got %b want 0", a2_out_valid); end
    mem_access(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, 32'h30C, cyc, stall, to);
    mem_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h310, cyc, stall, to);
    nvec++; if (to || a2_ld !== 32'h0BAD_F00D) begin nfail++; $display("FAIL flush_new: got %h want 0badf00d", a2_ld); end
  endtask

  task automatic test_out_of_range();
    int cyc, stall; bit to;
    mem_access(1'b0, 1'b1, 32'h0, 32'h600D_CAFE, 32'h400, cyc, stall, to);
    mem_access(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 32'h404, cyc, stall, to);
    nvec++; if (to || a2_err !== 1'b1) begin nfail++; $display("FAIL oor_st: err %b want 1", a2_err); end
    mem_access(1'b1, 1'b0, 32'h1000, 32'h0, 32'h408, cyc, stall, to);
    nvec++; if (to || a2_err !== 1'b1 || a2_ld !== 32'h0) begin nfail++; $display("FAIL oor_ld: err %b ld %h want 1 0", a2_err, a2_ld); end
    mem_access(1'b1, 1'b0, 32'h0, 32'h0, 32'h40C, cyc, stall, to);
    nvec++; if (to || a2_err !== 1'b0 || a2_ld !== 32'h600D_CAFE) begin nfail++; $display("FAIL oor_word0: err %b ld %h want 0 600dcafe", a2_err, a2_ld); end
  endtask

  task automatic test_reset_mid_wait();
    int cyc, stall; bit to;
    mem_access(1'b0, 1'b1, 32'h20, 32'h5555_AAAA, 32'h500, cyc, stall, to);
    drive(32'h504, 32'h20, 32'h1234, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    nvec++; if (a2_out_valid !== 1'b0 || a2_pc !== 32'h0 || a2_alu !== 32'h0 || a2_is_st !== 1'b0 || a2_regs !== 16'h0) begin
      nfail++; $display("FAIL rstw_outs: valid %b pc %h alu %h st %b regs %h want 0", a2_out_valid, a2_pc, a2_alu, a2_is_st, a2_regs);
    end
    step();
    rst = 1'b1;
    step();
    nvec++; if (a2_in_ready !== 1'b1) begin nfail++; $display("FAIL rstw_ready: got %b want 1", a2_in_ready); end
    mem_access(1'b1, 1'b0, 32'h20, 32'h0, 32'h508, cyc, stall, to);
    nvec++; if (to || a2_ld !== 32'h5555_AAAA) begin nfail++; $display("FAIL rstw_nowrite: got %h want 5555aaaa", a2_ld); end
  endtask

`ifdef MEM_BYTE_EN
  task automatic test_byte_en();
    int cyc, stall; bit to;
    size_i = 2'b10; sext_i = 1'b0;
    mem_access(1'b0, 1'b1, 32'h40, 32'h80FF_7F01, 32'h600, cyc, stall, to);
    size_i = 2'b00; sext_i = 1'b1;
    mem_access(1'b1, 1'b0, 32'h43, 32'h0, 32'h604, cyc, stall, to);
    nvec++; if (to || a2_ld !== 32'hFFFF_FF80) begin nfail++; $display("FAIL be_lb: got %h want ffffff80", a2_ld); end
    size_i = 2'b01; sext_i = 1'b0;
    mem_access(1'b1, 1'b0, 32'h41, 32'h0, 32'h608, cyc, stall, to);
    nvec++; if (to || a2_err !== 1'b1 || a2_ld !== 32'h0) begin nfail++; $display("FAIL be_lh_mis: err %b ld %h want 1 0", a2_err, a2_ld); end
    size_i = 2'b00;
    mem_access(1'b0, 1'b1, 32'h42, 32'h0000_00AA, 32'h60C, cyc, stall, to);
    size_i = 2'b10;
    mem_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h610, cyc, stall, to);
    nvec++; if (to || a2_ld !== 32'h80AA_7F01) begin nfail++; $display("FAIL be_sb: got %h want 80aa7f01", a2_ld); end
  endtask
`endif

  initial begin
    test_reset();
    test_lat0_stream();
    test_store_load();
    test_flush();
    test_out_of_range();
    test_reset_mid_wait();
`ifdef MEM_BYTE_EN
    test_byte_en();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
